// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_bit_counter.sv
// Data-bit counter: advances on each en pulse and wraps, done marks the last index.
module Bit_Counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  count <= '0;
        else if (en) count <= count + 1'b1;
    end

    assign done = &count;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, baud divider and 8N1 framing FSM.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 16,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   txd,
    output logic                   busy,
    output logic [2:0]             bit_idx
);

    localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    tx_state_t              state;
    logic [DIV_W-1:0]       div;
    logic [UART_DATA_W-1:0] shreg;
    logic                   bit_end;
    logic                   bit_en;
    logic                   bit_done;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    assign bit_end  = (div == DIV_LAST);
    assign bit_en   = (state == DATA) && bit_end;
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div <= '0;
                    if (tx_valid) begin
                        shreg <= tx_data;
                        state <= START;
                    end
                end
                START: begin
                    div <= bit_end ? '0 : div + 1'b1;
                    if (bit_end) state <= DATA;
                end
                // Last data bit is flagged by the counter, not by a local count.
                DATA: begin
                    div <= bit_end ? '0 : div + 1'b1;
                    if (bit_end) begin
                        if (bit_done) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            shreg <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    div <= bit_end ? '0 : div + 1'b1;
                    if (bit_end) state <= STOP;
                end
`endif
                STOP: begin
                    div <= bit_end ? '0 : div + 1'b1;
                    if (bit_end) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    div   <= '0;
                end
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        parity <= 1'b0;
        else if (state == IDLE && tx_valid) parity <= ^tx_data;
    end
`endif

    // Decoded from registered state so reset forces the idle level immediately.
    always_comb begin
        txd = IDLE_LEVEL;
        case (state)
            START:   txd = START_BIT;
            DATA:    txd = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd = parity;
`endif
            default: txd = IDLE_LEVEL;
        endcase
    end

    Bit_Counter #(.W(3)) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bit_en),
        .count (bit_idx),
        .done  (bit_done)
    );

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller of the 8-bit UART. It accepts a byte over a valid/ready handshake and serialises it on txd as 8N1: start bit, 8 data bits LSB first, stop bit.
- Contains the baud divider and the TX state machine.
- Drives the existing Bit_Counter sub-module: pulses its en once per data bit and uses its done to leave the data phase.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- IDLE_LEVEL, 1'b1, line level in idle and stop states.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send; sampled only on handshake
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  controller can accept a byte
- txd  output  1  serial line
- busy  output  1  frame in progress
- bit_idx  output  3  current data-bit index, from Bit_Counter count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, txd = IDLE_LEVEL, tx_ready = 1, busy = 0.
  - Shift register and baud divider = 0.
  - Bit_Counter is reset by the same rst_n, so bit_idx = 0.
- Handshake: a transfer occurs on a clk edge with tx_valid && tx_ready. tx_data is latched into an 8-bit shift register. tx_ready is high only in IDLE.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START on handshake. txd drives 0 starting the next cycle (1-cycle latency).
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: txd = shreg[0]. At each bit-period end:
    - if done = 0: pulse en for 1 cycle and shift shreg right.
    - if done = 1 (8th bit, count 7): pulse en (counter wraps to 0), then go to PARITY if enabled, else STOP.
  - STOP: txd = IDLE_LEVEL for CLKS_PER_BIT cycles, then IDLE.
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles.
  - Divider counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Divider width is $clog2(CLKS_PER_BIT).
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity. busy = (state != IDLE).
- Back-to-back frames: tx_ready rises in the cycle after the stop bit ends. With tx_valid held high, the next byte is accepted in that first IDLE cycle. The idle-high gap is therefore exactly 1 clk.
- en to Bit_Counter is asserted only in DATA at bit-period ends: exactly 8 pulses per frame. bit_idx is 0 at START and at the end of every frame.
- Boundary conditions:
  - tx_valid while busy: ignored, no latch.
  - tx_data changing mid-frame: no effect.
  - Reset mid-frame: immediate return to reset values; txd goes to IDLE_LEVEL asynchronously.
  - tx_valid held across reset deassertion: accepted on the first clk edge after reset release.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. txd = even parity (XOR of the latched byte), held CLKS_PER_BIT cycles. The parity bit is computed at latch time.
- Undefined: the PARITY state, its logic and the parity register are absent. DATA goes directly to STOP; frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - UART_DATA_W = 8
  - START_BIT = 1'b0, STOP_BIT = 1'b1
- Sub-module: the existing Bit_Counter is instantiated once as the data-bit counter; no new counter logic.
- The baud divider stays inline.

Test Plan:
- Reset, then idle: txd = 1, tx_ready = 1, busy = 0, bit_idx = 0 for 50 cycles with tx_valid = 0.
- CLKS_PER_BIT = 4, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clks. tx_ready is low for exactly 40 clks. Exactly 8 en pulses; bit_idx ends at 0.
- Back-to-back 0x00 then 0xFF with tx_valid held -> second start bit begins exactly 1 clk after the first stop bit ends. Bits decode correctly.
- tx_valid pulsed with 0x3C mid-frame -> ignored; the frame in progress is unchanged and no extra frame is sent.
- rst_n asserted in DATA at bit 4 -> txd = 1 immediately, tx_ready = 1, bit_idx = 0. A following 0x81 frame is transmitted cleanly.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT = 4: 0xA5 -> parity bit 0 and 44-clk frame; 0x01 -> parity bit 1.
